ccff_chain_loader: RTL

Upstream driver for the fabric configuration chain. It accepts configuration words over a valid/ready stream and serialises them LSB-first onto the head of the configuration flip-flop chain, one bit per shift cycle. It counts exactly CHAIN_LEN bits, then raises the configuration-enable that commits the chain contents to the fabric. It also captures the bits emerging from the chain tail for readback.

---
 rtl/ccff_chain_loader_if.sv | 11 +
 rtl/ccff_chain_loader.sv | 88 ++++++++
 2 files changed

// File: rtl/ccff_chain_loader_if.sv
// rtl/ccff_chain_loader_if.sv - configuration word stream between a word source and the chain loader
interface ccff_chain_loader_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serialises configuration words LSB-first into the CCFF chain and commits it
module ccff_chain_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    ccff_chain_loader_if.slave   s,
    output logic                 ccff_head,
    output logic                 cfg_shift_en,
    input  logic                 ccff_tail,
    output logic                 cfg_en,
    output logic                 cfg_done,
    output logic                 busy,
    output logic [WORD_W-1:0]    tail_word
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int BW = $clog2(WORD_W + 1);
    localparam int AW = ((CW > BW) ? CW : BW) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    state_t state, state_nxt;

    logic [WORD_W-1:0] sreg;
    logic [BW-1:0]     bits_left;
    logic [CW-1:0]     bits_sent;

    logic          shift, xfer, start_ok, last_bit;
    logic [AW-1:0] buffered, sent_nxt, room;
    logic [BW-1:0] take;

    assign shift    = (state == LOAD) && (bits_left != '0);
    assign buffered = AW'(bits_sent) + AW'(bits_left);
    // Accept the next word while the last buffered bit is still shifting, so words run back-to-back.
    assign s.s_ready = (state == LOAD) && (bits_left <= BW'(1)) && (buffered < AW'(CHAIN_LEN));
    assign xfer     = s.s_valid && s.s_ready;
    assign start_ok = start && (state != LOAD);
    assign sent_nxt = AW'(bits_sent) + (shift ? AW'(1) : AW'(0));
    assign last_bit = shift && (sent_nxt == AW'(CHAIN_LEN));
    assign room     = AW'(CHAIN_LEN) - sent_nxt;
    assign take     = (room > AW'(WORD_W)) ? BW'(WORD_W) : BW'(room);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (last_bit) state_nxt = DONE;
            DONE:    if (start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            sreg      <= '0;
            bits_left <= '0;
            bits_sent <= '0;
            tail_word <= '0;
        end else begin
            if (shift) begin
                sreg      <= sreg >> 1;
                bits_left <= bits_left - 1'b1;
                bits_sent <= sent_nxt[CW-1:0];
                tail_word <= {ccff_tail, tail_word[WORD_W-1:1]};
            end
            // A transfer on the final shift edge of a word overrides the shift of sreg/bits_left.
            if (xfer) begin
                sreg      <= s.s_data;
                bits_left <= take;
            end
        end
    end

    assign ccff_head    = sreg[0];
    assign cfg_shift_en = shift;
    assign cfg_en       = (state == DONE);
    assign cfg_done     = (state == DONE);
    assign busy         = (state == LOAD);
endmodule
